// File: rtl/sd_pkg.sv
// Shared definitions for the SD command path: frame geometry, CRC7 tap
// constant, framer state encoding and the serial CRC7 update step.
package sd_pkg;

  localparam int SD_CMD_FRAME_BITS = 48;
  localparam int SD_CMD_HDR_BITS   = 40;
  localparam int SD_CRC7_BITS      = 7;
  localparam int SD_NCC_BITS       = 8;

  // x^7 + x^3 + 1 with the x^7 term implied by the feedback
  localparam logic [6:0] SD_CRC7_TAP = 7'h09;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_CRC,
    ST_END,
    ST_GAP
  } sd_cmd_state_e;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic d);
    crc7_step = {c[5:0], 1'b0} ^ ((d ^ c[6]) ? SD_CRC7_TAP : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7_ser.sv
// Serial CRC7 engine: synchronous clear, one-bit absorb per enable, and a
// shift-out mode that moves the remainder towards bit 6 with zero fill.
module sd_crc7_ser
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       shift,
  input  logic       d,
  output logic [6:0] crc
);

  logic [6:0] crc_nxt;

  always_comb begin
    crc_nxt = crc;
    if (clr) begin
      crc_nxt = '0;
    end else if (en) begin
      crc_nxt = crc7_step(crc, d);
    end else if (shift) begin
      crc_nxt = {crc[5:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= '0;
    end else begin
      crc <= crc_nxt;
    end
  end

endmodule

// File: rtl/sd_cmd_tx.sv
// SD CMD-line framer: serialises start/tx/index/arg/CRC7/end MSB first, one
// bit per sd_tick. Define SD_CMD_NCC_EN to append the 8-bit Ncc high gap.
module sd_cmd_tx
  import sd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sd_tick,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        cmd_out,
  output logic        cmd_oe
);

  localparam logic [5:0] HDR_LAST = 6'(SD_CMD_HDR_BITS - 1);
  localparam logic [5:0] CRC_LAST = 6'(SD_CMD_HDR_BITS + SD_CRC7_BITS - 1);
`ifdef SD_CMD_NCC_EN
  localparam logic [5:0] GAP_LAST = 6'(SD_CMD_FRAME_BITS + SD_NCC_BITS - 1);
`endif

  sd_cmd_state_e               state, state_nxt;
  logic [SD_CMD_HDR_BITS-1:0]  shift_reg, shift_nxt;
  logic [5:0]                  bit_cnt, cnt_nxt;
  logic                        cmd_out_nxt, cmd_oe_nxt, done_nxt;
  logic                        crc_clr, crc_en, crc_shift;
  logic [6:0]                  crc;
  logic                        crc_unused;

  sd_crc7_ser u_crc (
    .clk   (clk),
    .rst   (rst),
    .clr   (crc_clr),
    .en    (crc_en),
    .shift (crc_shift),
    .d     (shift_reg[SD_CMD_HDR_BITS-1]),
    .crc   (crc)
  );

  // Bit 6 never receives feedback, so after either an absorb or a shift the
  // new msb is the old bit 5; that is the only CRC bit the line needs.
  assign crc_unused = ^{crc[6], crc[4:0]};

  assign ready = (state == ST_IDLE);
  assign busy  = ~ready;

  // NOTE: every signal driven here gets a default first so no path infers a latch.
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_reg;
    cnt_nxt     = bit_cnt;
    cmd_out_nxt = cmd_out;
    cmd_oe_nxt  = cmd_oe;
    done_nxt    = 1'b0;
    crc_clr     = 1'b0;
    crc_en      = 1'b0;
    crc_shift   = 1'b0;

    case (state)
      ST_IDLE: begin
        cmd_out_nxt = 1'b1;
        cmd_oe_nxt  = 1'b0;
        if (start) begin
          state_nxt   = ST_HDR;
          shift_nxt   = {1'b0, 1'b1, cmd_index, cmd_arg};
          cnt_nxt     = '0;
          crc_clr     = 1'b1;
          cmd_out_nxt = 1'b0;
          cmd_oe_nxt  = 1'b1;
        end
      end

      ST_HDR: begin
        if (sd_tick) begin
          crc_en    = 1'b1;
          shift_nxt = {shift_reg[SD_CMD_HDR_BITS-2:0], 1'b0};
          cnt_nxt   = bit_cnt + 6'd1;
          if (bit_cnt == HDR_LAST) begin
            state_nxt   = ST_CRC;
            cmd_out_nxt = crc[5];
          end else begin
            cmd_out_nxt = shift_reg[SD_CMD_HDR_BITS-2];
          end
        end
      end

      ST_CRC: begin
        if (sd_tick) begin
          crc_shift = 1'b1;
          cnt_nxt   = bit_cnt + 6'd1;
          if (bit_cnt == CRC_LAST) begin
            state_nxt   = ST_END;
            cmd_out_nxt = 1'b1;
          end else begin
            cmd_out_nxt = crc[5];
          end
        end
      end

      ST_END: begin
        if (sd_tick) begin
          cnt_nxt     = bit_cnt + 6'd1;
          cmd_out_nxt = 1'b1;
`ifdef SD_CMD_NCC_EN
          state_nxt   = ST_GAP;
`else
          state_nxt   = ST_IDLE;
          cmd_oe_nxt  = 1'b0;
          done_nxt    = 1'b1;
`endif
        end
      end

`ifdef SD_CMD_NCC_EN
      ST_GAP: begin
        if (sd_tick) begin
          cnt_nxt     = bit_cnt + 6'd1;
          cmd_out_nxt = 1'b1;
          if (bit_cnt == GAP_LAST) begin
            state_nxt  = ST_IDLE;
            cmd_oe_nxt = 1'b0;
            done_nxt   = 1'b1;
          end
        end
      end
`endif

      default: begin
        state_nxt   = ST_IDLE;
        cmd_out_nxt = 1'b1;
        cmd_oe_nxt  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all flops see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      cmd_out   <= 1'b1;
      cmd_oe    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      bit_cnt   <= cnt_nxt;
      cmd_out   <= cmd_out_nxt;
      cmd_oe    <= cmd_oe_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Self-checking bench for sd_cmd_tx: table of command vectors plus hand-written
// back-to-back, dropped-start, stall and mid-frame reset sequences.
module tb_sd_cmd_tx;
  import sd_pkg::*;

`ifdef SD_CMD_NCC_EN
  localparam int TICKS = SD_CMD_FRAME_BITS + SD_NCC_BITS;
`else
  localparam int TICKS = SD_CMD_FRAME_BITS;
`endif

  logic        clk, rst, sd_tick, start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        ready, busy, done, cmd_out, cmd_oe;

  sd_cmd_tx dut (
    .clk       (clk),
    .rst       (rst),
    .sd_tick   (sd_tick),
    .start     (start),
    .cmd_index (cmd_index),
    .cmd_arg   (cmd_arg),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .cmd_out   (cmd_out),
    .cmd_oe    (cmd_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q[$];
  int consumed = 0;
  int period   = 1;
  int tphase   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference CRC7 by polynomial long division of the 40 header bits.
  function automatic logic [6:0] ref_crc7(input logic [39:0] hdr);
    logic [46:0] v;
    v = {hdr, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    end
    return v[6:0];
  endfunction

  function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] hdr;
    hdr = {2'b01, idx, arg};
    return {hdr, ref_crc7(hdr), 1'b1};
  endfunction

  task automatic set_period(input int p);
    period = p;
    tphase = 0;
  endtask

  // sd_tick generator: one tick every 'period' cycles, none when period is 0
  initial begin
    sd_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (period == 0) begin
        sd_tick = 1'b0;
      end else begin
        sd_tick = (tphase == 0);
        tphase  = (tphase + 1 >= period) ? 0 : tphase + 1;
      end
    end
  end

  // Monitor: every consumed tick pops one expected line bit; bits must hold between ticks
  logic prev_oe = 1'b0, prev_out = 1'b1, prev_tick = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_oe = 1'b0;
      end else begin
        if (cmd_oe && sd_tick) begin
          consumed++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_underflow: got bit %0b, expected no bit (t=%0t)", cmd_out, $time);
          end else begin
            check("sb_bit", 64'(cmd_out), 64'(exp_q.pop_front()));
          end
        end
        if (cmd_oe && prev_oe && !prev_tick) check("bit_hold", 64'(cmd_out), 64'(prev_out));
        prev_oe   = cmd_oe;
        prev_out  = cmd_out;
        prev_tick = sd_tick;
      end
    end
  end

  task automatic push_frame(input logic [47:0] frame);
    for (int i = 47; i >= 0; i--) exp_q.push_back(frame[i]);
`ifdef SD_CMD_NCC_EN
    for (int i = 0; i < SD_NCC_BITS; i++) exp_q.push_back(1'b1);
`endif
  endtask

  // Called at a negedge; request is accepted at the following posedge.
  task automatic send(input logic [5:0] idx, input logic [31:0] arg, input logic [47:0] frame);
    check("ready_at_start", 64'(ready), 64'd1);
    start     = 1'b1;
    cmd_index = idx;
    cmd_arg   = arg;
    push_frame(frame);
    consumed  = 0;
    @(posedge clk);
    #1;
    start     = 1'b0;
    cmd_index = 6'($urandom);
    cmd_arg   = $urandom;
    @(negedge clk);
    check("start_oe", 64'(cmd_oe), 64'd1);
    check("start_bit", 64'(cmd_out), 64'd0);
    check("busy_after_accept", 64'(busy), 64'd1);
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  // Returns at the negedge of the done cycle.
  task automatic wait_done(input string name);
    bit found;
    found = 1'b0;
    for (int c = 0; c < 3000 && !found; c++) begin
      @(negedge clk);
      if (done === 1'b1) found = 1'b1;
    end
    if (!found) $display("FAIL %s: done never seen", name);
    check("done_seen", 64'(found), 64'd1);
    check("tick_count", 64'(consumed), 64'(TICKS));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("done_oe", 64'(cmd_oe), 64'd0);
    check("done_line", 64'(cmd_out), 64'd1);
    check("done_ready", 64'(ready), 64'd1);
  endtask

  task automatic wait_ticks(input int n);
    for (int c = 0; c < 5000 && consumed < n; c++) begin
      @(negedge clk);
      #1;
    end
    check("reach_tick", 64'(consumed >= n), 64'd1);
  endtask

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    int          per;
    logic [47:0] frame;
  } vec_t;

  vec_t vecs[6];
  logic held;
  int   held_c;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{6'd0,  32'h00000000, 1, 48'h400000000095};
    vecs[1] = '{6'd8,  32'h000001AA, 4, 48'h48000001AA87};
    vecs[2] = '{6'd17, 32'h00000000, 2, 48'h510000000055};
    vecs[3] = '{6'd55, 32'h00000000, 3, 48'h770000000065};
    vecs[4] = '{6'd41, 32'h40FF8000, 1, mk_frame(6'd41, 32'h40FF8000)};
    vecs[5] = '{6'h3F, 32'hDEADBEEF, 5, mk_frame(6'h3F, 32'hDEADBEEF)};

    rst       = 1'b1;
    start     = 1'b0;
    cmd_index = '0;
    cmd_arg   = '0;
    set_period(1);
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_line", 64'(cmd_out), 64'd1);
    check("rst_oe", 64'(cmd_oe), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      set_period(vecs[v].per);
      @(negedge clk);
      send(vecs[v].idx, vecs[v].arg, vecs[v].frame);
      wait_done("vector");
      @(negedge clk);
      check("idle_after_done", 64'(done), 64'd0);
    end

    // Back-to-back: CMD17 then CMD55 requested in the done cycle
    set_period(1);
    @(negedge clk);
    send(6'd17, 32'h0, 48'h510000000055);
    wait_done("b2b_first");
    send(6'd55, 32'h0, 48'h770000000065);
    wait_done("b2b_second");

    // start mid-frame is dropped and the frame is unaffected
    set_period(2);
    @(negedge clk);
    send(6'd8, 32'h000001AA, 48'h48000001AA87);
    wait_ticks(15);
    @(negedge clk);
    check("busy_mid_frame", 64'(ready), 64'd0);
    start     = 1'b1;
    cmd_index = 6'd1;
    cmd_arg   = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("drop_start");
    repeat (4) @(negedge clk);
    check("dropped_no_replay", 64'(cmd_oe), 64'd0);

    // sd_tick withheld: line holds the current bit indefinitely
    set_period(1);
    @(negedge clk);
    send(6'd17, 32'h12345678, mk_frame(6'd17, 32'h12345678));
    wait_ticks(10);
    set_period(0);
    @(negedge clk);
    #1;
    held   = cmd_out;
    held_c = consumed;
    repeat (30) @(negedge clk);
    #1;
    check("stall_line", 64'(cmd_out), 64'(held));
    check("stall_oe", 64'(cmd_oe), 64'd1);
    check("stall_done", 64'(done), 64'd0);
    check("stall_ticks", 64'(consumed), 64'(held_c));
    set_period(3);
    wait_done("stall_resume");

    // Async reset at bit 20 abandons the frame
    set_period(1);
    @(negedge clk);
    send(6'd8, 32'h000001AA, 48'h48000001AA87);
    wait_ticks(20);
    rst = 1'b1;
    #1;
    check("arst_oe", 64'(cmd_oe), 64'd0);
    check("arst_ready", 64'(ready), 64'd1);
    check("arst_line", 64'(cmd_out), 64'd1);
    check("arst_done", 64'(done), 64'd0);
    exp_q.delete();
    @(negedge clk);
    check("arst_done_hold", 64'(done), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_done", 64'(done), 64'd0);
    check("post_rst_ready", 64'(ready), 64'd1);
    check("post_rst_oe", 64'(cmd_oe), 64'd0);
    send(6'd0, 32'h0, 48'h400000000095);
    wait_done("after_reset");

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_cmd_tx.md
# sd_cmd_tx

SD-bus command framer. Accepts a 6-bit command index and a 32-bit argument and serialises the full 48-bit SD command frame onto the CMD line, MSB first, one bit per SD clock tick. The frame is start bit, transmission bit, index, argument, CRC7 and end bit. The block owns and sequences the serial CRC7 engine: it clears the engine, feeds it the first 40 frame bits, then shifts the CRC out. It sits between the host command scheduler and the CMD pad.

## Interface
- No parameters; frame format is fixed by the SD physical layer.
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- sd_tick  in  1  one-cycle strobe per SD clock period; all bit advances occur only on cycles with sd_tick=1
- start  in  1  request to send; accepted only when ready=1
- cmd_index  in  6  command index; sampled on acceptance
- cmd_arg  in  32  argument; sampled on acceptance
- ready  out  1  idle, can accept start
- busy  out  1  frame in progress (equals ~ready)
- done  out  1  one-cycle pulse when the frame (and gap, if configured) completes
- cmd_out  out  1  CMD line data, registered
- cmd_oe  out  1  CMD line output enable, registered

## Operation
- States: IDLE, HDR (40 bits: start, tx, index, arg), CRC (7 bits), END (1 bit), GAP (only with macro), then back to IDLE.
- Acceptance happens in the cycle where start=1 and ready=1.
  - A 40-bit shift register loads {1'b0, 1'b1, cmd_index, cmd_arg}.
  - The CRC engine is synchronously cleared.
  - The 6-bit bit counter is set to 0.
- start while busy is ignored; no queuing.
- HDR: cmd_out = shift_reg[39]. On each sd_tick, the CRC engine absorbs cmd_out, the shift register shifts left and the counter increments. The tick that ends bit 39 moves the FSM to CRC.
- CRC: cmd_out = crc[6]. On each sd_tick, the CRC register shifts left with 0 fill and the engine is not updated. After 7 ticks the FSM moves to END.
- END: cmd_out = 1. On the next sd_tick the FSM moves to GAP, or to IDLE if the macro is absent.
- CRC7 polynomial is x^7+x^3+1, register initialised to 0.
  - next[0] = d ^ c[6]
  - next[3] = c[2] ^ d ^ c[6]
  - all other bits are plain shifts.
- Reset values: ready=1, busy=0, done=0, cmd_out=1, cmd_oe=0, state IDLE, counter 0, CRC 0.

## Timing
- Acceptance in cycle N: cmd_oe=1 and cmd_out=0 (start bit) are visible from cycle N+1.
- Each bit holds from the cycle after one sd_tick to the cycle of the next consumed tick, inclusive.
- An sd_tick in cycle N itself is not consumed by the new frame.
- Frame length is exactly 48 consumed ticks.
- On the cycle after the final consumed tick:
  - cmd_oe=0, cmd_out=1, done=1 for exactly one cycle, ready=1.
  - A start in that same cycle is accepted (back-to-back frames).
- sd_tick stuck high: one bit per clk cycle, so the frame takes 48 cycles.
- sd_tick never asserted: the block holds the current bit indefinitely; no timeout.
- Async reset mid-frame: cmd_oe drops immediately, no done pulse, and the partial frame is abandoned.

## Configuration
- SD_CMD_NCC_EN defined: after END, the GAP state drives cmd_oe=1, cmd_out=1 for 8 further sd_ticks (the Ncc minimum). done and ready follow the 8th gap tick, for 56 ticks total.
- SD_CMD_NCC_EN undefined: the GAP state does not exist and done follows the end-bit tick (48 ticks).

## Structure
- Shared package sd_pkg holds:
  - state enum
  - SD_CMD_FRAME_BITS=48, SD_CMD_HDR_BITS=40, SD_CRC7_BITS=7, SD_NCC_BITS=8
  - CRC7 tap constant 7'h09
- One sub-module, sd_crc7_ser: serial CRC7 with sync clear, enable, data in, 7-bit state out, and a shift-out mode (shift left with 0 fill) used in the CRC state.

## Test plan
- CMD0, arg 0x00000000, sd_tick every cycle: serial stream equals 0x40_00000000_95; done on the cycle after tick 48.
- CMD8, arg 0x000001AA, sd_tick every 4th cycle: stream 0x48_000001AA_87; each bit is stable for 4 cycles.
- CMD17 then CMD55, with start asserted in the done cycle: frames 0x51_00000000_55 and 0x77_00000000_65 back-to-back; cmd_oe stays low for exactly one cycle between them.
- start pulsed mid-frame with different index and argument: the current frame is unaffected and the second request is dropped.
- rst asserted at bit 20: cmd_oe=0 in the same cycle, no done, ready=1 after release; the next CMD0 is correct.
- With SD_CMD_NCC_EN, CMD0: 8 high bits with cmd_oe=1 after 0x95; done after 56 ticks.
